// File: rtl/transmissor_medida_pkg.sv
// Shared encodings for the measurement frame transmitter: FSM states, ASCII
// constants and frame geometry.
package transmissor_medida_pkg;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_LOAD = 4'd1;
  localparam logic [3:0] ST_SEND = 4'd2;
  localparam logic [3:0] ST_WAIT = 4'd3;
  localparam logic [3:0] ST_NEXT = 4'd4;
  localparam logic [3:0] ST_DONE = 4'd5;

  localparam logic [6:0] ASCII_VIRGULA   = 7'h2C;
  localparam logic [6:0] ASCII_CERQUILHA = 7'h23;
  localparam logic [6:0] ASCII_ZERO      = 7'h30;

  localparam int FRAME_LEN     = 8;
  localparam int BITS_PER_CHAR = 10;

  // Digits above 9 are not clamped; they map straight onto 0x3A..0x3F.
  function automatic logic [6:0] digito_ascii(input logic [3:0] bcd);
    return ASCII_ZERO + {3'b000, bcd};
  endfunction

endpackage

// File: rtl/transmissor_medida_tx_serial.sv
// 7O1 UART character serialiser with baud down-counter and a one-deep pending
// slot so the next character can start right after the current stop bit.
module tx_serial_7o1
  import transmissor_medida_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dados,
  output logic       saida,
  output logic       pronto,
  output logic       ocioso
);

  localparam int             BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0]  BAUD_MAX = BW'(BAUD_DIV - 1);
  localparam logic [3:0]     BIT_MAX  = 4'(BITS_PER_CHAR - 1);

  logic [9:0]    quadro;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic          ativo;
  logic          pend_valid;
  logic [6:0]    pend_dados;
  logic          fim_bit;
  logic          fim_char;
  logic          carrega;
  logic [6:0]    prox_dados;

  // Bit 0 is on the line: start, 7 data bits LSB first, odd parity, stop.
  function automatic logic [9:0] monta_quadro(input logic [6:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  assign fim_bit  = ativo && (baud_cnt == '0);
  assign fim_char = fim_bit && (bit_cnt == 4'd0);

  always_comb begin
    carrega    = 1'b0;
    prox_dados = dados;
    if (!ativo) begin
      carrega = partida;
    end else if (fim_char) begin
      carrega    = partida || pend_valid;
      prox_dados = partida ? dados : pend_dados;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quadro     <= '1;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      ativo      <= 1'b0;
      pend_valid <= 1'b0;
      pend_dados <= '0;
      pronto     <= 1'b0;
    end else begin
      // Pronto marks entry into the stop bit, leaving the whole stop bit to
      // queue the next character.
      pronto <= fim_bit && (bit_cnt == 4'd1);
      if (carrega) begin
        quadro     <= monta_quadro(prox_dados);
        baud_cnt   <= BAUD_MAX;
        bit_cnt    <= BIT_MAX;
        ativo      <= 1'b1;
        pend_valid <= 1'b0;
      end else begin
        if (fim_char) begin
          ativo  <= 1'b0;
          quadro <= '1;
        end else if (fim_bit) begin
          quadro   <= {1'b1, quadro[9:1]};
          baud_cnt <= BAUD_MAX;
          bit_cnt  <= bit_cnt - 4'd1;
        end else if (ativo) begin
          baud_cnt <= baud_cnt - 1'b1;
        end
        if (ativo && partida) begin
          pend_valid <= 1'b1;
          pend_dados <= dados;
        end
      end
    end
  end

  assign saida  = quadro[0];
  assign ocioso = !ativo && !pend_valid;

endmodule

// File: rtl/transmissor_medida.sv
// Measurement frame transmitter: sends "a2a1a0,d2d1d0#" over a 7O1 UART line.
//   state | meaning
//   IDLE  | waiting for transmitir
//   LOAD  | latch angulo/distancia, index = 0
//   SEND  | hand current character to the serialiser
//   WAIT  | character in progress
//   NEXT  | advance index or finish
//   DONE  | wait for line to drain, pulse envio_pronto
module transmissor_medida
  import transmissor_medida_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        transmitir,
  input  logic [11:0] angulo,
  input  logic [11:0] distancia,
  output logic        saida_serial,
  output logic        envio_pronto,
  output logic        ocupado,
  output logic [3:0]  db_estado
);

  localparam logic [2:0] IDX_ULT = 3'(FRAME_LEN - 1);

  logic [3:0]  estado;
  logic [3:0]  prox_estado;
  logic [2:0]  indice;
  logic [11:0] ang_reg;
  logic [11:0] dist_reg;
  logic [6:0]  caractere;
  logic        indice_fim;
  logic        tx_pronto;
  logic        tx_ocioso;

  assign indice_fim = (indice == IDX_ULT);

  always_comb begin
    case (indice)
      3'd0:    caractere = digito_ascii(ang_reg[11:8]);
      3'd1:    caractere = digito_ascii(ang_reg[7:4]);
      3'd2:    caractere = digito_ascii(ang_reg[3:0]);
      3'd3:    caractere = ASCII_VIRGULA;
      3'd4:    caractere = digito_ascii(dist_reg[11:8]);
      3'd5:    caractere = digito_ascii(dist_reg[7:4]);
      3'd6:    caractere = digito_ascii(dist_reg[3:0]);
      default: caractere = ASCII_CERQUILHA;
    endcase
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      ST_IDLE: if (transmitir) prox_estado = ST_LOAD;
      ST_LOAD: prox_estado = ST_SEND;
      ST_SEND: prox_estado = ST_WAIT;
      ST_WAIT: if (tx_pronto) prox_estado = ST_NEXT;
      ST_NEXT: prox_estado = indice_fim ? ST_DONE : ST_SEND;
      ST_DONE: if (tx_ocioso) prox_estado = ST_IDLE;
      default: prox_estado = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= ST_IDLE;
      indice   <= '0;
      ang_reg  <= '0;
      dist_reg <= '0;
    end else begin
      estado <= prox_estado;
      if (estado == ST_LOAD) begin
        ang_reg  <= angulo;
        dist_reg <= distancia;
        indice   <= '0;
      end else if (estado == ST_NEXT && !indice_fim) begin
        indice <= indice + 3'd1;
      end
    end
  end

  tx_serial_7o1 #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clock   (clock),
    .reset   (reset),
    .partida (estado == ST_SEND),
    .dados   (caractere),
    .saida   (saida_serial),
    .pronto  (tx_pronto),
    .ocioso  (tx_ocioso)
  );

  // DONE holds until the final stop bit has left the line.
  assign envio_pronto = (estado == ST_DONE) && tx_ocioso;
  assign ocupado      = (estado != ST_IDLE) && !envio_pronto;
  assign db_estado    = estado;

endmodule

// File: tb/tb_transmissor_medida.sv
// Directed bench for transmissor_medida at BAUD_DIV=4 with a line decoder.
module tb_transmissor_medida;

  localparam int BAUD_DIV = 4;
  localparam int CHAR_CYC = 10 * BAUD_DIV;

  logic        clock = 1'b0;
  logic        reset;
  logic        transmitir;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        saida_serial;
  logic        envio_pronto;
  logic        ocupado;
  logic [3:0]  db_estado;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit         dec_active = 1'b0;
  int         dec_pos    = 0;
  logic       dec_cur;
  logic [9:0] dec_bits;
  int         glitch_cnt = 0;
  logic [9:0] char_q[$];
  int         start_q[$];

  transmissor_medida #(.BAUD_DIV(BAUD_DIV)) dut (
    .clock        (clock),
    .reset        (reset),
    .transmitir   (transmitir),
    .angulo       (angulo),
    .distancia    (distancia),
    .saida_serial (saida_serial),
    .envio_pronto (envio_pronto),
    .ocupado      (ocupado),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Line decoder: every bit must hold its value for BAUD_DIV samples.
  initial forever begin
    @(negedge clock);
    if (reset === 1'b1) begin
      dec_active = 1'b0;
    end else begin
      if (!dec_active && saida_serial === 1'b0) begin
        dec_active = 1'b1;
        dec_pos    = 0;
        start_q.push_back(cyc);
      end
      if (dec_active) begin
        if (dec_pos % BAUD_DIV == 0) dec_cur = saida_serial;
        else if (saida_serial !== dec_cur) glitch_cnt++;
        if (dec_pos % BAUD_DIV == BAUD_DIV - 1) dec_bits[dec_pos / BAUD_DIV] = dec_cur;
        dec_pos++;
        if (dec_pos == CHAR_CYC) begin
          char_q.push_back(dec_bits);
          dec_active = 1'b0;
        end
      end
    end
  end

  task automatic send_and_check(input string nm, input logic [11:0] a, input logic [11:0] d,
                                input logic [55:0] exp, input bit noise, input int tail);
    int ca, lat, ep_n, ocup_err, g0, sp_err;
    bit seen;
    logic [9:0] ch;
    logic [6:0] e;
    char_q.delete();
    start_q.delete();
    g0 = glitch_cnt;
    angulo = a;
    distancia = d;
    transmitir = 1'b1;
    @(negedge clock);
    transmitir = 1'b0;
    ca = cyc;
    n_tests++;
    if (ocupado !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ocupado_rise: got %b want 1", nm, ocupado);
    end
    seen = 1'b0; ep_n = 0; ocup_err = 0; lat = 0;
    for (int k = 1; k <= 420; k++) begin
      if (noise && k == 100) begin angulo = 12'h999; distancia = 12'h888; transmitir = 1'b1; end
      if (noise && k == 101) transmitir = 1'b0;
      if (noise && k == 150) begin angulo = 12'h777; distancia = 12'h111; end
      @(negedge clock);
      if (envio_pronto === 1'b1) begin
        ep_n++;
        if (!seen) begin
          seen = 1'b1;
          lat = cyc - ca;
          if (ocupado !== 1'b0) ocup_err++;
        end
      end else if (!seen && ocupado !== 1'b1) begin
        ocup_err++;
      end
      if (seen && (cyc - ca - lat) >= tail) break;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL %s_timeout: no envio_pronto within 420 cycles", nm); end
    n_tests++;
    if (lat < 317 || lat > 323) begin n_fail++; $display("FAIL %s_latency: got %0d want 320+-3", nm, lat); end
    n_tests++;
    if (ep_n != 1) begin n_fail++; $display("FAIL %s_pulses: got %0d want 1", nm, ep_n); end
    n_tests++;
    if (ocup_err != 0) begin n_fail++; $display("FAIL %s_ocupado: got %0d bad cycles want 0", nm, ocup_err); end
    n_tests++;
    if (start_q.size() == 0 || start_q[0] - ca > 3) begin
      n_fail++;
      $display("FAIL %s_first_start: got %0d starts want first within 3 cycles", nm, start_q.size());
    end
    n_tests++;
    if (char_q.size() != 8) begin n_fail++; $display("FAIL %s_count: got %0d chars want 8", nm, char_q.size()); end
    for (int i = 0; i < 8 && i < char_q.size(); i++) begin
      ch = char_q[i];
      e  = exp[55 - 7*i -: 7];
      n_tests++;
      if (ch[7:1] !== e || (^ch[8:1]) !== 1'b1 || ch[9] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_char%0d: got data %h par %b stop %b want data %h odd parity stop 1",
                 nm, i, ch[7:1], ch[8], ch[9], e);
      end
    end
    sp_err = 0;
    for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != CHAR_CYC) sp_err++;
    n_tests++;
    if (sp_err != 0) begin n_fail++; $display("FAIL %s_spacing: got %0d gaps want 0", nm, sp_err); end
    n_tests++;
    if (glitch_cnt != g0) begin
      n_fail++;
      $display("FAIL %s_bit_width: got %0d unstable samples want 0", nm, glitch_cnt - g0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    transmitir = 1'b0;
    angulo = '0;
    distancia = '0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (saida_serial !== 1'b1) begin n_fail++; $display("FAIL reset_line: got %b want 1", saida_serial); end
    n_tests++;
    if (envio_pronto !== 1'b0) begin n_fail++; $display("FAIL reset_envio: got %b want 0", envio_pronto); end
    n_tests++;
    if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado: got %b want 0", ocupado); end
    n_tests++;
    if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (db_estado !== 4'd0 || saida_serial !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_reset: got estado %0d line %b want 0 and 1", db_estado, saida_serial);
    end
  endtask

  task automatic test_frame_basic();
    send_and_check("basic", 12'h090, 12'h025,
                   {7'h30, 7'h39, 7'h30, 7'h2C, 7'h30, 7'h32, 7'h35, 7'h23}, 1'b0, 10);
  endtask

  task automatic test_inputs_during_frame();
    send_and_check("noise", 12'h245, 12'h310,
                   {7'h32, 7'h34, 7'h35, 7'h2C, 7'h33, 7'h31, 7'h30, 7'h23}, 1'b1, 10);
  endtask

  task automatic test_digit_above_9();
    send_and_check("digit_a", 12'h1A0, 12'h025,
                   {7'h31, 7'h3A, 7'h30, 7'h2C, 7'h30, 7'h32, 7'h35, 7'h23}, 1'b0, 5);
  endtask

  task automatic test_reset_mid_frame();
    int ep_n, busy;
    char_q.delete();
    start_q.delete();
    angulo = 12'h090;
    distancia = 12'h025;
    transmitir = 1'b1;
    @(negedge clock);
    transmitir = 1'b0;
    for (int k = 0; k < 400 && start_q.size() < 5; k++) @(negedge clock);
    n_tests++;
    if (start_q.size() < 5) begin
      n_fail++;
      $display("FAIL midreset_wait: got %0d starts want 5", start_q.size());
    end
    n_tests++;
    if (saida_serial !== 1'b0) begin n_fail++; $display("FAIL midreset_pre_line: got %b want 0", saida_serial); end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (saida_serial !== 1'b1) begin n_fail++; $display("FAIL midreset_line: got %b want 1", saida_serial); end
    n_tests++;
    if (ocupado !== 1'b0 || envio_pronto !== 1'b0 || db_estado !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ocupado %b envio %b estado %0d want 0 0 0",
               ocupado, envio_pronto, db_estado);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ep_n = 0;
    busy = 0;
    repeat (400) begin
      @(negedge clock);
      if (envio_pronto === 1'b1) ep_n++;
      if (ocupado !== 1'b0) busy++;
    end
    n_tests++;
    if (ep_n != 0 || busy != 0) begin
      n_fail++;
      $display("FAIL midreset_abandon: got %0d pulses %0d busy cycles want 0 0", ep_n, busy);
    end
    send_and_check("after_reset", 12'h360, 12'h199,
                   {7'h33, 7'h36, 7'h30, 7'h2C, 7'h31, 7'h39, 7'h39, 7'h23}, 1'b0, 5);
  endtask

  task automatic test_back_to_back();
    send_and_check("b2b_a", 12'h123, 12'h456,
                   {7'h31, 7'h32, 7'h33, 7'h2C, 7'h34, 7'h35, 7'h36, 7'h23}, 1'b0, 0);
    // Request raised during the envio_pronto cycle and held one more cycle.
    angulo = 12'h789;
    distancia = 12'h000;
    transmitir = 1'b1;
    @(negedge clock);
    n_tests++;
    if (ocupado !== 1'b0 || db_estado !== 4'd0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: got ocupado %b estado %0d want 0 0", ocupado, db_estado);
    end
    send_and_check("b2b_b", 12'h789, 12'h000,
                   {7'h37, 7'h38, 7'h39, 7'h2C, 7'h30, 7'h30, 7'h30, 7'h23}, 1'b0, 5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    transmitir = 1'b0;
    angulo = '0;
    distancia = '0;
    test_reset();
    test_frame_basic();
    test_inputs_during_frame();
    test_digit_above_9();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
